// File: rtl/regfile_v3.sv
// regfile_v3: parametrised register file with hardwired zero register,
// write-through bypass, per-register pending scoreboard for hazard detection
// and a sequential clear engine that zeroes one entry per cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// SWEEP | clear engine zeroing mem[ptr] each edge; requests ignored
// IDLE  | normal operation: reads, writebacks, allocations
module regfile_v3 #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   output logic              busy,
   input  logic              rs_req,
   input  logic [AWIDTH-1:0] rs_addr,
   output logic [DWIDTH-1:0] rs_data,
   output logic              rs_valid,
   input  logic              rt_req,
   input  logic [AWIDTH-1:0] rt_addr,
   output logic [DWIDTH-1:0] rt_data,
   output logic              rt_valid,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              alloc_en,
   input  logic [AWIDTH-1:0] alloc_addr,
   output logic              alloc_ready
);

   localparam int NREGS = 1 << AWIDTH;
   localparam logic [AWIDTH-1:0] PTR_FIRST = AWIDTH'(1);
   localparam logic [AWIDTH-1:0] PTR_LAST  = '1;
   localparam logic [AWIDTH-1:0] ADDR_ZERO = '0;

   typedef enum logic {SWEEP, IDLE} state_t;

   state_t            state;
   logic [AWIDTH-1:0] ptr;
   logic [NREGS-1:0]  pending;
   logic [DWIDTH-1:0] mem [NREGS];

   logic wr_ok;
   logic alloc_ok;

   assign busy        = (state == SWEEP);
   assign wr_ok       = !busy && wr_en && (wr_addr != ADDR_ZERO);
   assign alloc_ready = !busy && ((alloc_addr == ADDR_ZERO) || !pending[alloc_addr]);
   assign alloc_ok    = alloc_en && alloc_ready && (alloc_addr != ADDR_ZERO);

   // Sweep sequencing and scoreboard; allocation is applied after the write
   // so a same-cycle producer leaves the register pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= SWEEP;
         ptr     <= PTR_FIRST;
         pending <= '0;
      end else if (clear) begin
         state   <= SWEEP;
         ptr     <= PTR_FIRST;
         pending <= '0;
      end else if (state == SWEEP) begin
         ptr <= ptr + AWIDTH'(1);
         if (ptr == PTR_LAST) begin
            state <= IDLE;
         end
      end else begin
         if (wr_ok) begin
            pending[wr_addr] <= 1'b0;
         end
         if (alloc_ok) begin
            pending[alloc_addr] <= 1'b1;
         end
      end
   end

   // Register array: no reset, contents established by the sweep; a clear
   // request on the same edge takes precedence over sweep and writeback.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (busy) begin
            mem[ptr] <= '0;
         end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
         end
      end
   end

   // rs read port, priority: request, busy, zero register, bypass, array.
   always_comb begin
      rs_data  = '0;
      rs_valid = 1'b0;
      if (rs_req && !busy) begin
         if (rs_addr == ADDR_ZERO) begin
            rs_valid = 1'b1;
         end else if (wr_en && (wr_addr == rs_addr)) begin
            rs_data  = wr_data;
            rs_valid = 1'b1;
         end else begin
            rs_data  = mem[rs_addr];
            rs_valid = !pending[rs_addr];
         end
      end
   end

   // rt read port, same priority as rs.
   always_comb begin
      rt_data  = '0;
      rt_valid = 1'b0;
      if (rt_req && !busy) begin
         if (rt_addr == ADDR_ZERO) begin
            rt_valid = 1'b1;
         end else if (wr_en && (wr_addr == rt_addr)) begin
            rt_data  = wr_data;
            rt_valid = 1'b1;
         end else begin
            rt_data  = mem[rt_addr];
            rt_valid = !pending[rt_addr];
         end
      end
   end

endmodule

// File: tb/tb_regfile_v3.sv
// Directed testbench for regfile_v3: default 3-bit address instance plus a
// 4-bit address instance to exercise full-width zero-register decode.
module tb_regfile_v3;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        busy;
   logic        rs_req, rt_req;
   logic [2:0]  rs_addr, rt_addr;
   logic [15:0] rs_data, rt_data;
   logic        rs_valid, rt_valid;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        alloc_en;
   logic [2:0]  alloc_addr;
   logic        alloc_ready;

   logic        clear4;
   logic        busy4;
   logic        rs4_req, rt4_req;
   logic [3:0]  rs4_addr, rt4_addr;
   logic [15:0] rs4_data, rt4_data;
   logic        rs4_valid, rt4_valid;
   logic        wr4_en;
   logic [3:0]  wr4_addr;
   logic [15:0] wr4_data;
   logic        alloc4_en;
   logic [3:0]  alloc4_addr;
   logic        alloc4_ready;

   int nvec = 0;
   int nmis = 0;
   int n3, n4, cnt;

   regfile_v3 #(.DWIDTH(16), .AWIDTH(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
      .rs_req(rs_req), .rs_addr(rs_addr), .rs_data(rs_data), .rs_valid(rs_valid),
      .rt_req(rt_req), .rt_addr(rt_addr), .rt_data(rt_data), .rt_valid(rt_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready)
   );

   regfile_v3 #(.DWIDTH(16), .AWIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear4), .busy(busy4),
      .rs_req(rs4_req), .rs_addr(rs4_addr), .rs_data(rs4_data), .rs_valid(rs4_valid),
      .rt_req(rt4_req), .rt_addr(rt4_addr), .rt_data(rt4_data), .rt_valid(rt4_valid),
      .wr_en(wr4_en), .wr_addr(wr4_addr), .wr_data(wr4_data),
      .alloc_en(alloc4_en), .alloc_addr(alloc4_addr), .alloc_ready(alloc4_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counts edges after reset release until each instance drops busy.
   task automatic sweep_count(output int c3, output int c4);
      c3 = 0;
      c4 = 0;
      for (int i = 1; i <= 24; i++) begin
         @(posedge clk);
         #1;
         if (!busy && c3 == 0) c3 = i;
         if (!busy4 && c4 == 0) c4 = i;
         if (c3 != 0 && c4 != 0) break;
      end
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 1; a < 8; a++) begin
         @(negedge clk);
         rs_addr = 3'(a);
         rt_addr = 3'(a);
         #1;
         check({tag, "_rs_data"}, rs_data, 0);
         check({tag, "_rs_valid"}, rs_valid, 1);
         check({tag, "_rt_data"}, rt_data, 0);
         check({tag, "_rt_valid"}, rt_valid, 1);
      end
   endtask

   task automatic load_all(input logic [15:0] val);
      for (int a = 1; a < 8; a++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = 3'(a);
         wr_data = val;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;  clear = 1'b0;
      rs_req = 1'b1; rs_addr = 3'd0; rt_req = 1'b1; rt_addr = 3'd3;
      wr_en = 1'b0;  wr_addr = 3'd0; wr_data = 16'h0;
      alloc_en = 1'b0; alloc_addr = 3'd3;
      clear4 = 1'b0; rs4_req = 1'b1; rs4_addr = 4'd0; rt4_req = 1'b1; rt4_addr = 4'd0;
      wr4_en = 1'b0; wr4_addr = 4'd0; wr4_data = 16'h0;
      alloc4_en = 1'b0; alloc4_addr = 4'd0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 1);
      check("rst_rs_valid", rs_valid, 0);
      check("rst_rs_data", rs_data, 0);
      check("rst_rt_valid", rt_valid, 0);
      check("rst_alloc_ready", alloc_ready, 0);

      @(negedge clk);
      rst_n = 1'b1;
      sweep_count(n3, n4);
      check("sweep_len", n3, 7);
      check("sweep_len4", n4, 15);
      read_all_zero("init");

      // Write to r0 is dropped.
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF; rs_addr = 3'd0;
      #1;
      check("r0_wr_cycle_data", rs_data, 0);
      check("r0_wr_cycle_valid", rs_valid, 1);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      check("r0_after_data", rs_data, 0);
      check("r0_after_valid", rs_valid, 1);

      // Allocation of r3, then writeback with bypass.
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 3'd3; rs_addr = 3'd3;
      #1;
      check("alloc3_ready_pre", alloc_ready, 1);
      check("alloc3_valid_pre", rs_valid, 1);
      @(negedge clk);
      alloc_en = 1'b0;
      #1;
      check("r3_pending_valid", rs_valid, 0);
      check("r3_pending_ready", alloc_ready, 0);
      check("r3_pending_data", rs_data, 0);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h00A5;
      #1;
      check("r3_bypass_data", rs_data, 16'h00A5);
      check("r3_bypass_valid", rs_valid, 1);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      check("r3_mem_data", rs_data, 16'h00A5);
      check("r3_mem_valid", rs_valid, 1);
      check("r3_ready_again", alloc_ready, 1);

      // Same-cycle write and allocation: new producer wins.
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0011;
      alloc_en = 1'b1; alloc_addr = 3'd5; rs_addr = 3'd5;
      @(negedge clk);
      wr_en = 1'b0; alloc_en = 1'b0;
      #1;
      check("r5_data", rs_data, 16'h0011);
      check("r5_valid", rs_valid, 0);
      check("r5_ready", alloc_ready, 0);

      // No request: outputs idle.
      @(negedge clk);
      rs_req = 1'b0;
      #1;
      check("noreq_data", rs_data, 0);
      check("noreq_valid", rs_valid, 0);
      rs_req = 1'b1;

      // Fill, allocate r4, then clear with a write attempted through the sweep.
      load_all(16'hFFFF);
      rt_addr = 3'd4;
      #1;
      check("fill_r4_data", rt_data, 16'hFFFF);
      check("fill_r4_valid", rt_valid, 1);
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 3'd4;
      @(negedge clk);
      alloc_en = 1'b0; clear = 1'b1;
      #1;
      check("r4_pending_ready", alloc_ready, 0);
      @(negedge clk);
      clear = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777; rs_addr = 3'd2;
      #1;
      check("clr_busy", busy, 1);
      check("clr_rs_data", rs_data, 0);
      check("clr_rs_valid", rs_valid, 0);
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            cnt = i;
            break;
         end
      end
      check("clear_len", cnt, 7);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      check("clr_r2_data", rs_data, 0);
      check("clr_r2_valid", rs_valid, 1);
      check("clr_r4_ready", alloc_ready, 1);
      read_all_zero("clr");

      // Reset pulled mid-sweep with ptr at 4.
      load_all(16'h5A5A);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1);
      @(negedge clk);
      #1;
      check("midrst_busy_held", busy, 1);
      check("midrst_rs_valid", rs_valid, 0);
      rst_n = 1'b1;
      sweep_count(n3, n4);
      check("resweep_len", n3, 7);
      check("resweep_len4", n4, 15);
      read_all_zero("rst");

      // Four-bit address instance: r8 is a real register, r0 stays zero.
      @(negedge clk);
      wr4_en = 1'b1; wr4_addr = 4'd8; wr4_data = 16'h1234;
      @(negedge clk);
      wr4_addr = 4'd0; wr4_data = 16'hBEEF; rt4_addr = 4'd0;
      #1;
      check("a4_r0_wr_cycle", rt4_data, 0);
      @(negedge clk);
      wr4_en = 1'b0; rs4_addr = 4'd8;
      #1;
      check("a4_r8_data", rs4_data, 16'h1234);
      check("a4_r8_valid", rs4_valid, 1);
      check("a4_r0_data", rt4_data, 0);
      check("a4_r0_valid", rt4_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
